// File: rtl/mul_req_ctrl_if.sv
// Signal bundle between mul_req_ctrl (master side), the operand/result streams and the multiplier unit.
interface mul_req_ctrl_if #(
  parameter int SEQ_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             mul_start;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic             mul_busy;
  logic             mul_done;
  logic [31:0]      mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_prod;
  logic [SEQ_W-1:0] out_seq;
  logic             timeout_err;

  modport master (
    input  in_valid, in_a, in_b, mul_busy, mul_done, mul_prod, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, out_seq, timeout_err
  );

  modport slave (
    output in_valid, in_a, in_b, mul_busy, mul_done, mul_prod, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_prod, out_seq, timeout_err
  );
endinterface

// File: rtl/mul_req_ctrl.sv
// Requester front end for the start/busy/done 16x16 multiplier: one operation in flight, in-order tagged results.
// Optional WAIT-state watchdog is compiled in with `define MUL_REQ_TIMEOUT_EN.
module mul_req_ctrl #(
  parameter int SEQ_W     = 4,
  parameter int OUT_DEPTH = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_req_ctrl_if.master io_bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OUT_DEPTH);

  logic [1:0]       r_state;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [SEQ_W-1:0] r_seq;

  logic [31:0]      r_prodMem [OUT_DEPTH];
  logic [SEQ_W-1:0] r_seqMem  [OUT_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;

  logic w_inReady;
  logic w_accept;
  logic w_start;
  logic w_push;
  logic w_pop;
  logic w_expire;

  // Accepting only with a free buffer slot reserves room for the eventual push.
  assign w_inReady = (r_state == S_IDLE) && (r_count < FULL_CNT);
  assign w_accept  = io_bus.in_valid && w_inReady;
  assign w_start   = (r_state == S_ISSUE) && !io_bus.mul_busy;
  assign w_push    = (r_state == S_CAPT);
  assign w_pop     = (r_count != '0) && io_bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_seq   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= io_bus.in_a;
            r_b     <= io_bus.in_b;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!io_bus.mul_busy) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (io_bus.mul_done)  r_state <= S_CAPT;
          else if (w_expire)    r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // An abandoned transaction still consumes its tag so the gap shows downstream.
      if (w_push || w_expire) r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_prodMem[i] <= '0;
        r_seqMem[i]  <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_prodMem[r_wrPtr] <= io_bus.mul_prod;
        r_seqMem[r_wrPtr]  <= r_seq;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

`ifdef MUL_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdCnt;
  logic            r_err;

  // A done pulse in the expiry cycle takes priority over the timeout.
  assign w_expire = (r_state == S_WAIT) && !io_bus.mul_done &&
                    (r_wdCnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdCnt <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_wdCnt <= r_wdCnt + 1'b1;
      else                   r_wdCnt <= '0;
      if (w_expire) r_err <= 1'b1;
    end
  end

  assign io_bus.timeout_err = r_err;
`else
  assign w_expire = 1'b0;
  // Without the watchdog the flag is constant 0 for any legal TIMEOUT (>= 1).
  assign io_bus.timeout_err = (TIMEOUT < 0);
`endif

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.mul_start = w_start;
  assign io_bus.mul_a     = r_a;
  assign io_bus.mul_b     = r_b;
  assign io_bus.out_valid = (r_count != '0);
  assign io_bus.out_prod  = r_prodMem[r_rdPtr];
  assign io_bus.out_seq   = r_seqMem[r_rdPtr];
endmodule

// File: tb/tb_mul_req_ctrl.sv
// Self-checking bench for mul_req_ctrl: emulated multiplier unit, transaction-level reference model, directed and random tests.
module tb_mul_req_ctrl;
  localparam int SEQ_W     = 4;
  localparam int OUT_DEPTH = 2;
  localparam int TIMEOUT   = 8;
  localparam int SEQ_MOD   = 1 << SEQ_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_req_ctrl_if #(.SEQ_W(SEQ_W)) bus ();

  mul_req_ctrl #(.SEQ_W(SEQ_W), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Multiplier unit stand-in: busy for 2 (+random) cycles after start, done in the last busy cycle, product one cycle later.
  logic        uBusy        = 1'b0;
  logic        forceBusy    = 1'b0;
  logic        suppressDone = 1'b0;
  logic        randomMode   = 1'b0;
  int          uRem         = 0;
  logic [31:0] uA           = '0;
  logic [31:0] uB           = '0;
  assign bus.mul_busy = uBusy | forceBusy;

  always @(posedge clk) begin : unitModel
    logic        st;
    logic        wasDone;
    logic [15:0] ca;
    logic [15:0] cb;
    st = bus.mul_start; wasDone = bus.mul_done; ca = bus.mul_a; cb = bus.mul_b;
    #1;
    if (!rst_n) begin
      uRem = 0; uBusy = 1'b0; bus.mul_done = 1'b0; bus.mul_prod = $urandom;
    end else begin
      if (st) begin
        uRem = 2 + (randomMode ? $urandom_range(0, 2) : 0);
        uA = {16'h0, ca}; uB = {16'h0, cb};
      end else if (uRem > 0) begin
        uRem--;
      end
      bus.mul_prod = wasDone ? uA * uB : $urandom;
      uBusy = (uRem > 0);
      bus.mul_done = !suppressDone &&
                     ((uRem == 1) || (randomMode && uRem == 0 && $urandom_range(0, 7) == 0));
    end
  end

  // Reference model: one transaction record plus a queue of results owed downstream.
  bit          mActive, mStarted, mDoneSeen, mErr, expReady, popNow;
  int          mWait, mSeq;
  logic [15:0] mA, mB;
  logic [31:0] qProd[$];
  int          qSeq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mActive = 0; mStarted = 0; mDoneSeen = 0; mErr = 0; mWait = 0; mSeq = 0;
      qProd.delete(); qSeq.delete();
    end else begin
      expReady = !mActive && (qProd.size() < OUT_DEPTH);
      checkOutput("in_ready", bus.in_ready, expReady);
      checkOutput("mul_start", bus.mul_start, mActive && !mStarted && !bus.mul_busy);
      if (mActive) begin
        checkOutput("mul_a", bus.mul_a, mA);
        checkOutput("mul_b", bus.mul_b, mB);
      end
      checkOutput("out_valid", bus.out_valid, qProd.size() != 0);
      if (qProd.size() != 0) begin
        checkOutput("out_prod", bus.out_prod, qProd[0]);
        checkOutput("out_seq", bus.out_seq, qSeq[0]);
      end
      checkOutput("timeout_err", bus.timeout_err, mErr);

      popNow = (qProd.size() != 0) && bus.out_ready;
      if (popNow) begin
        void'(qProd.pop_front());
        void'(qSeq.pop_front());
      end
      if (!mActive) begin
        if (bus.in_valid && expReady) begin
          mActive = 1; mStarted = 0; mDoneSeen = 0; mA = bus.in_a; mB = bus.in_b;
        end
      end else if (!mStarted) begin
        if (!bus.mul_busy) begin
          mStarted = 1; mWait = 0;
        end
      end else if (!mDoneSeen) begin
        if (bus.mul_done) mDoneSeen = 1;
        else begin
          mWait++;
`ifdef MUL_REQ_TIMEOUT_EN
          if (mWait == TIMEOUT) begin
            mErr = 1; mSeq = (mSeq + 1) % SEQ_MOD; mActive = 0;
          end
`endif
        end
      end else begin
        qProd.push_back({16'h0, mA} * {16'h0, mB});
        qSeq.push_back(mSeq);
        mSeq = (mSeq + 1) % SEQ_MOD;
        mActive = 0;
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #2;
    rst_n = 1'b0; forceBusy = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mul_start", bus.mul_start, 0);
    checkOutput("rst_mul_a", {bus.mul_a, bus.mul_b}, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_prod", bus.out_prod, 0);
    checkOutput("rst_out_seq", bus.out_seq, 0);
    checkOutput("rst_timeout_err", bus.timeout_err, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready_rise", bus.in_ready, 1);
  endtask

  task automatic waitAccept();
    bit got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    waitAccept();
  endtask

  task automatic getResult(output logic [31:0] p, output int s);
    bit got = 0;
    p = '0; s = -1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1; p = bus.out_prod; s = bus.out_seq;
      end
    end
    if (!got) checkOutput("result_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL sim_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    logic [31:0] p;
    int          s;
    logic [31:0] bpExp[3];
    logic [15:0] wa[17];
    logic [15:0] wb[17];
    int          starts;
    int          firstStart;
    bit          stopDrv;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;

    // Single operation: start in cycle 1, result visible in cycle 5.
    doReset();
    applyStimulus(16'd3, 16'd5);
    @(negedge clk); checkOutput("single_start_c1", bus.mul_start, 1);
    @(negedge clk); checkOutput("single_start_c2", bus.mul_start, 0);
    @(negedge clk);
    @(negedge clk); checkOutput("single_valid_c4", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("single_valid_c5", bus.out_valid, 1);
    checkOutput("single_prod", bus.out_prod, 32'd15);
    checkOutput("single_seq", bus.out_seq, 0);
    checkOutput("single_ready_c5", bus.in_ready, 1);

    applyStimulus(16'hFFFF, 16'hFFFF);
    getResult(p, s);
    checkOutput("max_prod", p, 32'hFFFE0001);
    checkOutput("max_seq", s, 1);
    applyStimulus(16'h0000, 16'h1234);
    getResult(p, s);
    checkOutput("zero_prod", p, 32'h0);
    checkOutput("zero_seq", s, 2);

    // Backpressure with a two-entry buffer.
    doReset();
    bus.out_ready = 1'b0;
    applyStimulus(16'd2, 16'd2);
    applyStimulus(16'd3, 16'd3);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 16'd4; bus.in_b = 16'd4;
    repeat (12) @(negedge clk);
    checkOutput("bp_in_ready_low", bus.in_ready, 0);
    checkOutput("bp_head_prod", bus.out_prod, 32'd4);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bpExp[0] = 32'd4; bpExp[1] = 32'd9; bpExp[2] = 32'd16;
    fork
      waitAccept();
      for (int k = 0; k < 3; k++) begin
        getResult(p, s);
        checkOutput("bp_prod", p, bpExp[k]);
        checkOutput("bp_seq", s, k);
      end
    join

    // Busy held for three ISSUE cycles delays the single start pulse to cycle 4.
    doReset();
    applyStimulus(16'h00AB, 16'h0CD0);
    forceBusy = 1'b1;
    starts = 0; firstStart = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.mul_start) begin
        starts++;
        if (firstStart < 0) firstStart = k;
      end
      if (k <= 7) begin
        checkOutput("busy_mul_a", bus.mul_a, 16'h00AB);
        checkOutput("busy_mul_b", bus.mul_b, 16'h0CD0);
      end
      if (k == 7) checkOutput("busy_valid_c7", bus.out_valid, 0);
      if (k == 8) begin
        checkOutput("busy_valid_c8", bus.out_valid, 1);
        checkOutput("busy_prod", bus.out_prod, 32'h00088EF0);
      end
      if (k == 3) begin
        @(posedge clk); #1;
        forceBusy = 1'b0;
      end
    end
    checkOutput("busy_start_count", starts, 1);
    checkOutput("busy_start_cycle", firstStart, 4);

    // Sequence tag wrap over 17 back-to-back operations.
    doReset();
    for (int i = 0; i < 17; i++) begin
      wa[i] = $urandom; wb[i] = $urandom;
    end
    fork
      for (int i = 0; i < 17; i++) applyStimulus(wa[i], wb[i]);
      for (int i = 0; i < 17; i++) begin
        getResult(p, s);
        checkOutput("wrap_prod", p, {16'h0, wa[i]} * {16'h0, wb[i]});
        checkOutput("wrap_seq", s, i % SEQ_MOD);
      end
    join

    // Suppressed done: watchdog fires (if compiled in) or the block stays parked in WAIT.
    doReset();
    suppressDone = 1'b1;
    applyStimulus(16'd1, 16'd2);
`ifdef MUL_REQ_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput("wd_no_valid", bus.out_valid, 0);
      if (k == 9)  checkOutput("wd_err_c9", bus.timeout_err, 0);
      if (k == 10) checkOutput("wd_err_c10", bus.timeout_err, 1);
    end
    @(posedge clk); #1;
    suppressDone = 1'b0;
    applyStimulus(16'd7, 16'd6);
    getResult(p, s);
    checkOutput("wd_next_prod", p, 32'd42);
    checkOutput("wd_next_seq", s, 1);
    checkOutput("wd_err_sticky", bus.timeout_err, 1);
    doReset();
`else
    repeat (20) @(negedge clk);
    checkOutput("nowd_no_valid", bus.out_valid, 0);
    checkOutput("nowd_parked", bus.in_ready, 0);
    checkOutput("nowd_err", bus.timeout_err, 0);
    @(posedge clk); #1;
    suppressDone = 1'b0;
    doReset();
    applyStimulus(16'd7, 16'd6);
    getResult(p, s);
    checkOutput("nowd_next_prod", p, 32'd42);
    checkOutput("nowd_next_seq", s, 0);
`endif

    // Random traffic: busy stalls, spurious done pulses, unit latency and backpressure all randomized.
    doReset();
    randomMode = 1'b1;
    stopDrv = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [15:0] ra;
          logic [15:0] rb;
          ra = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
          rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          applyStimulus(ra, rb);
        end
        stopDrv = 1;
      end
      while (!stopDrv) begin
        @(posedge clk); #1;
        forceBusy     = ($urandom_range(0, 3) == 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    randomMode = 1'b0; forceBusy = 1'b0; bus.out_ready = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("drain_empty", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
